// File: rtl/regfile_wr_arbiter.sv
// Two-requester round-robin write-port arbiter with multi-beat lock for the register file.
// Optional statistics counters are enabled by defining WRARB_STATS_EN.
module regfile_wr_arbiter #(
  parameter int WIDTH    = 64,
  parameter int ADDR_W   = 5,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_valid,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [WIDTH-1:0]  r0_data,
  input  logic              r0_lock,
  output logic              r0_ready,
  input  logic              r1_valid,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [WIDTH-1:0]  r1_data,
  input  logic              r1_lock,
  output logic              r1_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic              busy
`ifdef WRARB_STATS_EN
  ,
  output logic [15:0]       conflict_cnt,
  output logic [7:0]        lock_trunc
`endif
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;
  localparam logic [3:0] LOCK_MAX_C = 4'(LOCK_MAX);

  logic [0:0]        r_state;
  logic              r_owner;
  logic              r_prio;
  logic [3:0]        r_lock_cnt;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [WIDTH-1:0]  r_wr_data;

  logic              w_r0_ready;
  logic              w_r1_ready;
  logic              w_acc;
  logic              w_sel;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [WIDTH-1:0]  w_acc_data;
  logic              w_acc_lock;
  logic              w_at_max;

  // While locked only the owner may be served, even if it bubbles.
  always_comb begin
    w_r0_ready = 1'b0;
    w_r1_ready = 1'b0;
    if (!reset) begin
      if (r_state == S_LOCKED) begin
        w_r0_ready = r0_valid & ~r_owner;
        w_r1_ready = r1_valid &  r_owner;
      end else begin
        w_r0_ready = r0_valid & (~r1_valid | ~r_prio);
        w_r1_ready = r1_valid & (~r0_valid |  r_prio);
      end
    end
  end

  assign r0_ready   = w_r0_ready;
  assign r1_ready   = w_r1_ready;
  assign w_acc      = w_r0_ready | w_r1_ready;
  assign w_sel      = w_r1_ready;
  assign w_acc_addr = w_sel ? r1_addr : r0_addr;
  assign w_acc_data = w_sel ? r1_data : r0_data;
  assign w_acc_lock = w_sel ? r1_lock : r0_lock;
  assign w_at_max   = (r_lock_cnt == LOCK_MAX_C);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_owner    <= 1'b0;
      r_prio     <= 1'b0;
      r_lock_cnt <= 4'd0;
    end else if (w_acc) begin
      case (r_state)
        S_IDLE: begin
          r_prio <= ~w_sel;
          if (w_acc_lock) begin
            r_state    <= S_LOCKED;
            r_owner    <= w_sel;
            r_lock_cnt <= 4'd1;
          end
        end
        S_LOCKED: begin
          // Reaching LOCK_MAX forces the owner off so the other side cannot starve.
          if (!w_acc_lock || w_at_max) begin
            r_state    <= S_IDLE;
            r_prio     <= ~r_owner;
            r_lock_cnt <= 4'd0;
          end else begin
            r_lock_cnt <= r_lock_cnt + 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // X31 is the zero register: the handshake completes but no write is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_acc && (w_acc_addr != {ADDR_W{1'b1}});
      if (w_acc) begin
        r_wr_addr <= w_acc_addr;
        r_wr_data <= w_acc_data;
      end
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign busy    = (r_state == S_LOCKED);

`ifdef WRARB_STATS_EN
  logic [15:0] r_conflict_cnt;
  logic [7:0]  r_lock_trunc;
  logic        w_conflict;
  logic        w_trunc;

  assign w_conflict = r0_valid & r1_valid & (~w_r0_ready | ~w_r1_ready);
  assign w_trunc    = w_acc & (r_state == S_LOCKED) & w_at_max & w_acc_lock;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_conflict_cnt <= 16'd0;
      r_lock_trunc   <= 8'd0;
    end else begin
      if (w_conflict && (r_conflict_cnt != 16'hFFFF)) r_conflict_cnt <= r_conflict_cnt + 16'd1;
      if (w_trunc && (r_lock_trunc != 8'hFF)) r_lock_trunc <= r_lock_trunc + 8'd1;
    end
  end

  assign conflict_cnt = r_conflict_cnt;
  assign lock_trunc   = r_lock_trunc;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed scoreboard bench for regfile_wr_arbiter; expected writes are queued per step.
module tb_regfile_wr_arbiter;

  typedef struct packed {
    logic        en;
    logic [4:0]  addr;
    logic [63:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_valid, r0_lock, r0_ready;
  logic [4:0]  r0_addr;
  logic [63:0] r0_data;
  logic        r1_valid, r1_lock, r1_ready;
  logic [4:0]  r1_addr;
  logic [63:0] r1_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic        busy;
`ifdef WRARB_STATS_EN
  logic [15:0] conflict_cnt;
  logic [7:0]  lock_trunc;
`endif

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sbQueue[$];
  exp_t held = '0;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.WIDTH(64), .ADDR_W(5), .LOCK_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_data(r0_data), .r0_lock(r0_lock), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_data(r1_data), .r1_lock(r1_lock), .r1_ready(r1_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
`ifdef WRARB_STATS_EN
    , .conflict_cnt(conflict_cnt), .lock_trunc(lock_trunc)
`endif
  );

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs mid-period, check the combinational handshake and queue the write it implies.
  task automatic applyStimulus(input logic rst,
                               input logic v0, input logic [4:0] a0, input logic [63:0] d0, input logic l0,
                               input logic v1, input logic [4:0] a1, input logic [63:0] d1, input logic l1,
                               input logic er0, input logic er1, input logic eb);
    @(negedge clk);
    reset = rst;
    r0_valid = v0; r0_addr = a0; r0_data = d0; r0_lock = l0;
    r1_valid = v1; r1_addr = a1; r1_data = d1; r1_lock = l1;
    #1;
    checkEq("r0_ready", 64'(r0_ready), 64'(er0));
    checkEq("r1_ready", 64'(r1_ready), 64'(er1));
    checkEq("busy", 64'(busy), 64'(eb));
    if (rst) begin
      held = '0;
      sbQueue.push_back('0);
    end else if (er0 || er1) begin
      held.addr = er1 ? a1 : a0;
      held.data = er1 ? d1 : d0;
      held.en   = 1'b0;
      sbQueue.push_back('{en: (held.addr != 5'd31), addr: held.addr, data: held.data});
    end else begin
      sbQueue.push_back('{en: 1'b0, addr: held.addr, data: held.data});
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    @(posedge clk);
    #1;
    if (sbQueue.size() == 0) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = sbQueue.pop_front();
      checkEq("wr_en", 64'(wr_en), 64'(e.en));
      checkEq("wr_addr", 64'(wr_addr), 64'(e.addr));
      checkEq("wr_data", wr_data, e.data);
    end
  endtask

  task automatic step(input logic rst,
                      input logic v0, input logic [4:0] a0, input logic [63:0] d0, input logic l0,
                      input logic v1, input logic [4:0] a1, input logic [63:0] d1, input logic l1,
                      input logic er0, input logic er1, input logic eb);
    applyStimulus(rst, v0, a0, d0, l0, v1, a1, d1, l1, er0, er1, eb);
    checkOutput();
  endtask

  initial begin
    reset = 1'b1;
    r0_valid = 1'b0; r0_addr = '0; r0_data = '0; r0_lock = 1'b0;
    r1_valid = 1'b0; r1_addr = '0; r1_data = '0; r1_lock = 1'b0;
    @(posedge clk);

    $display("[TB] reset holds readies low and clears outputs");
    step(1, 1, 5'd3, 64'h1, 0, 1, 5'd2, 64'h2, 0, 0, 0, 0);

    $display("[TB] single write, then idle with changing addr/data");
    step(0, 1, 5'd3, 64'hDEAD_BEEF, 0, 0, 5'd0, 64'h0, 0, 1, 0, 0);
    step(0, 0, 5'd9, 64'h1234, 0, 0, 5'd12, 64'h5678, 0, 0, 0, 0);

    $display("[TB] contention round-robin");
    step(1, 0, 5'd0, 64'h0, 0, 0, 5'd0, 64'h0, 0, 0, 0, 0);
    step(0, 1, 5'd1, 64'h11, 0, 1, 5'd2, 64'h22, 0, 1, 0, 0);
    step(0, 1, 5'd1, 64'h11, 0, 1, 5'd2, 64'h22, 0, 0, 1, 0);
    step(0, 1, 5'd1, 64'h11, 0, 1, 5'd2, 64'h22, 0, 1, 0, 0);
    step(0, 1, 5'd1, 64'h11, 0, 1, 5'd2, 64'h22, 0, 0, 1, 0);

    $display("[TB] zero register write");
    step(0, 0, 5'd0, 64'h0, 0, 1, 5'd31, 64'h5, 0, 0, 1, 0);

    $display("[TB] lock pair owned by r1");
    step(0, 1, 5'd6, 64'h66, 0, 0, 5'd0, 64'h0, 0, 1, 0, 0);
    step(0, 1, 5'd7, 64'h77, 0, 1, 5'd4, 64'h44, 1, 0, 1, 0);
    step(0, 1, 5'd7, 64'h77, 0, 0, 5'd5, 64'h55, 0, 0, 0, 1);
    step(0, 1, 5'd7, 64'h77, 0, 1, 5'd5, 64'h55, 0, 0, 1, 1);
    step(0, 1, 5'd7, 64'h77, 0, 0, 5'd0, 64'h0, 0, 1, 0, 0);

    $display("[TB] lock truncation at LOCK_MAX");
    step(1, 0, 5'd0, 64'h0, 0, 0, 5'd0, 64'h0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      step(0, 1, 5'(8 + i), 64'(100 + i), 1, 1, 5'd20, 64'hCC, 0, 1, 0, (i != 0));
    step(0, 1, 5'd13, 64'd105, 1, 1, 5'd20, 64'hCC, 0, 0, 1, 0);
`ifdef WRARB_STATS_EN
    checkEq("lock_trunc", 64'(lock_trunc), 64'd1);
`endif

    $display("[TB] reset while locked");
    step(0, 1, 5'd10, 64'hA0, 1, 1, 5'd21, 64'hB0, 0, 1, 0, 0);
    step(1, 1, 5'd11, 64'hA1, 1, 1, 5'd21, 64'hB0, 0, 0, 0, 1);
    step(0, 1, 5'd12, 64'hA2, 0, 1, 5'd22, 64'hB2, 0, 1, 0, 0);
    step(0, 1, 5'd12, 64'hA2, 0, 1, 5'd22, 64'hB2, 0, 0, 1, 0);
    step(0, 0, 5'd0, 64'h0, 0, 0, 5'd0, 64'h0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Arbitrates two writeback requesters onto the single write port of the register file: r0 is the ALU/execute path and r1 is the memory/load path.
- The registered output (wr_en/wr_addr/wr_data) drives the enable and data inputs of the per-register enable-DFF banks.
- Round-robin fairness between the two requesters.
- A lock mechanism keeps a multi-beat writer (e.g. load-pair) on the port for consecutive beats.
- Writes to the zero register (X31) are acknowledged but never reach the port.

Parameters:
- WIDTH, 64, data width of one register.
- ADDR_W, 5, register address width.
- LOCK_MAX, 4, maximum consecutive locked beats before the lock is forcibly released (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- r0_valid  in  1  requester 0 has a write pending.
- r0_addr  in  ADDR_W  requester 0 destination register.
- r0_data  in  WIDTH  requester 0 write data.
- r0_lock  in  1  hold the grant for the next beat after this one.
- r0_ready  out  1  requester 0 accepted this cycle (combinational).
- r1_valid, r1_addr, r1_data, r1_lock, r1_ready  same as r0, for requester 1.
- wr_en  out  1  register-file write enable (registered).
- wr_addr  out  ADDR_W  register-file write address (registered).
- wr_data  out  WIDTH  register-file write data (registered).
- busy  out  1  arbiter is in the LOCKED state.

Behaviour:
- Single clock domain; reset is synchronous and active-high, and all state updates on the rising edge of clk.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, state=IDLE, prio=0 (r0 favoured), lock_cnt=0. While reset=1, r0_ready=r1_ready=0.
- Handshake:
  - A transfer occurs when rN_valid & rN_ready in the same cycle.
  - At most one ready is asserted per cycle.
  - Ready never asserts without the matching valid.
- IDLE arbitration:
  - Only one valid: grant it.
  - Both valid: grant the requester selected by prio.
  - After any accept in IDLE, prio <= the requester that was not granted.
- IDLE -> LOCKED(owner): taken when the accepted requester had rN_lock=1. On entry, lock_cnt <= 1 and busy=1 from the next cycle.
- LOCKED(owner):
  - Only the owner may receive ready. The other requester sees ready=0 even if the owner is idle (the owner may bubble without losing the lock).
  - Each owner accept with lock=1 increments lock_cnt.
  - Owner accept with lock=0 returns to IDLE.
  - If an owner accept occurs while lock_cnt==LOCK_MAX, the state returns to IDLE regardless of lock.
  - On any exit from LOCKED, prio <= the non-owner.
- Output latency is 1 cycle. The cycle after an accept, wr_addr/wr_data <= the accepted addr/data, and wr_en <= 1 unless addr==all-ones (X31).
- An X31 write completes the handshake normally but produces wr_en=0. wr_addr/wr_data still update.
- Cycles with no accept: wr_en <= 0; wr_addr/wr_data hold their previous values.
- Back-to-back accepts produce back-to-back wr_en pulses; there are no bubbles inserted by the arbiter.
- Reset asserted in any state (including mid-lock) returns everything to reset values on that edge. Any write accepted in the same cycle as reset is dropped.
- Inputs are sampled only on the accept edge. Addr/data changing while valid=0 have no effect.

Optional Feature:
- Macro: WRARB_STATS_EN.
- Defined:
  - Adds output port conflict_cnt [15:0], reset to 0.
  - Increments by 1 on each cycle where both rN_valid=1 and at least one requester is denied (one of the two ready outputs, or both, is 0).
  - Saturates at 16'hFFFF.
  - Also adds output port lock_trunc [7:0], reset to 0, counting LOCK_MAX-forced releases; saturates at 8'hFF.
- Undefined: neither port exists and there is no associated logic. Core behaviour is identical in both cases.

Test Plan:
1. Reset then single write:
   - Stimulus: r0_valid=1, addr=3, data=64'hDEAD_BEEF for one cycle.
   - Required: r0_ready=1 that cycle; next cycle wr_en=1, wr_addr=3, wr_data=64'hDEAD_BEEF; the cycle after, wr_en=0 with addr/data held.
2. Contention round-robin:
   - Stimulus: both valid for 4 cycles (r0 addr=1, r1 addr=2) after reset.
   - Required: grants r0, r1, r0, r1; wr_addr sequence 1,2,1,2 on consecutive cycles with wr_en=1 throughout.
3. Zero register:
   - Stimulus: r1_valid=1, addr=31, data=5.
   - Required: r1_ready=1; next cycle wr_en=0, wr_addr=31.
4. Lock pair:
   - Stimulus: r1 sends addr=4 with lock=1, then addr=5 with lock=0, while r0_valid=1 throughout.
   - Required: r0_ready=0 for both beats, busy=1 between them, wr_addr 4 then 5; r0 granted on the following cycle.
5. Lock truncation:
   - Stimulus: r0 holds lock=1 for 6 beats with LOCK_MAX=4 while r1_valid=1.
   - Required: after r0's 5th accept the state returns to IDLE; r1 granted on the next cycle; with WRARB_STATS_EN, lock_trunc=1.
6. Reset mid-lock:
   - Stimulus: assert reset for 1 cycle while LOCKED(r0) and r0 valid.
   - Required: no ready that cycle; next cycle wr_en=0, busy=0, r0 and r1 arbitrated fresh with prio=0.
